// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch unit.
package ifetch_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam logic [INSTR_W-1:0] DEFAULT_NOP_INSTR = 16'h0800;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/ifetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master) and memory (slave).
interface ifetch_unit_if
  import ifetch_pkg::*;
();

  logic               imem_req;
  logic [INSTR_W-1:0] imem_addr;
  logic               imem_ready;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/ifetch_unit.sv
// Single-entry instruction fetch unit: one outstanding memory request, redirect squashing.
// Optional IFETCH_ALIGN_CHECK_EN: flag odd redirect targets in sticky err and clear bit 0.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC  = 16'h0000,
  parameter logic [INSTR_W-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pc_wr_en,
  input  logic               redirect,
  input  logic [INSTR_W-1:0] redirect_pc,
  ifetch_unit_if.master      imem,
  output logic [INSTR_W-1:0] instr_out,
  output logic [INSTR_W-1:0] pc_plus2_out,
  output logic               instr_valid,
  output logic               err
);

  fetch_state_e       state_q, state_d;
  logic [INSTR_W-1:0] pc_q, pc_d;
  logic [INSTR_W-1:0] buf_q, buf_d;
  logic [INSTR_W-1:0] pp2_q, pp2_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic [INSTR_W-1:0] target;
  logic               fetch_req;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      buf_q   <= NOP_INSTR;
      pp2_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      pp2_q   <= pp2_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    buf_d     = buf_q;
    pp2_d     = pp2_q;
    valid_d   = valid_q;
`ifdef IFETCH_ALIGN_CHECK_EN
    target    = {redirect_pc[INSTR_W-1:1], 1'b0};
    err_d     = err_q | (redirect & redirect_pc[0]);
`else
    target    = redirect_pc;
    err_d     = 1'b0;
`endif
    fetch_req = (state_q == ST_IDLE) && !redirect && (!valid_q || pc_wr_en);

    if (redirect) begin
      pc_d    = target;
      valid_d = 1'b0;
      // A response landing in the redirect cycle retires the outstanding
      // request, so there is nothing left to drain in either busy state.
      if (state_q != ST_IDLE) begin
        state_d = imem.imem_rvalid ? ST_IDLE : ST_DRAIN;
      end
    end else begin
      if (valid_q && pc_wr_en) begin
        valid_d = 1'b0;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (fetch_req && imem.imem_ready) begin
            state_d = ST_WAIT;
            pc_d    = pc_q + 16'd2;
          end
        end
        ST_WAIT: begin
          if (imem.imem_rvalid) begin
            state_d = ST_IDLE;
            buf_d   = imem.imem_rdata;
            pp2_d   = pc_q;
            valid_d = 1'b1;
          end
        end
        ST_DRAIN: begin
          if (imem.imem_rvalid) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign imem.imem_req  = fetch_req;
  assign imem.imem_addr = pc_q;
  assign instr_out      = valid_q ? buf_q : NOP_INSTR;
  assign pc_plus2_out   = pp2_q;
  assign instr_valid    = valid_q;
  assign err            = err_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed vector table, corner sequences, random vs. model.
module tb_ifetch_unit;
  import ifetch_pkg::*;

`ifdef IFETCH_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  localparam logic [15:0] NOP = 16'h0800;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_wr_en, redirect;
  logic [15:0] redirect_pc;
  logic [15:0] instr_out, pc_plus2_out;
  logic        instr_valid, err;

  ifetch_unit_if imem_bus ();

  ifetch_unit #(.RESET_PC(16'h0000), .NOP_INSTR(16'h0800)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_wr_en    (pc_wr_en),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (imem_bus.master),
    .instr_out   (instr_out),
    .pc_plus2_out(pc_plus2_out),
    .instr_valid (instr_valid),
    .err         (err)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input logic wr, input logic rd, input logic [15:0] rpc,
                       input logic rdy, input logic rv, input logic [15:0] rdata);
    pc_wr_en             = wr;
    redirect             = rd;
    redirect_pc          = rpc;
    imem_bus.imem_ready  = rdy;
    imem_bus.imem_rvalid = rv;
    imem_bus.imem_rdata  = rdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A5A;
  endfunction

  typedef struct {
    logic        wr, rd;
    logic [15:0] rpc;
    logic        rdy, rv;
    logic [15:0] rdata;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_valid;
    logic [15:0] e_instr, e_pp2;
  } vec_t;

  vec_t vecs[$];

  // random-phase reference state
  logic [15:0] m_pc, m_bd, m_bpp2, m_oaddr;
  logic        m_busy, m_stale, m_bv, m_err;

  initial begin
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    //                wr rd rpc       rdy rv rdata      req addr     vld instr     pp2
    vecs.push_back('{1, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'h0000, 0, NOP,      16'h0000});
    vecs.push_back('{1, 0, 16'h0000, 1, 1, 16'h1111, 0, 16'h0000, 0, NOP,      16'h0000});
    vecs.push_back('{1, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'h0002, 1, 16'h1111, 16'h0002});
    vecs.push_back('{1, 0, 16'h0000, 1, 1, 16'h1234, 0, 16'h0000, 0, NOP,      16'h0002});
    vecs.push_back('{0, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h1234, 16'h0004});
    vecs.push_back('{0, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h1234, 16'h0004});
    vecs.push_back('{0, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h1234, 16'h0004});
    vecs.push_back('{1, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'h0004, 1, 16'h1234, 16'h0004});
    vecs.push_back('{1, 1, 16'h0040, 1, 0, 16'h0000, 0, 16'h0000, 0, NOP,      16'h0004});
    vecs.push_back('{1, 0, 16'h0000, 1, 1, 16'hAAAA, 0, 16'h0000, 0, NOP,      16'h0004});
    vecs.push_back('{1, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'h0040, 0, NOP,      16'h0004});
    vecs.push_back('{1, 1, 16'h0080, 1, 1, 16'hBBBB, 0, 16'h0000, 0, NOP,      16'h0004});
    vecs.push_back('{1, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'h0080, 0, NOP,      16'h0004});
    vecs.push_back('{1, 0, 16'h0000, 0, 1, 16'hCCCC, 0, 16'h0000, 0, NOP,      16'h0004});
    vecs.push_back('{0, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'hCCCC, 16'h0082});
    vecs.push_back('{0, 0, 16'h0000, 1, 1, 16'hDDDD, 0, 16'h0000, 1, 16'hCCCC, 16'h0082});

    foreach (vecs[i]) begin
      drive(vecs[i].wr, vecs[i].rd, vecs[i].rpc, vecs[i].rdy, vecs[i].rv, vecs[i].rdata);
      @(negedge clk);
      chk($sformatf("vec%0d req", i), 16'(imem_bus.imem_req), 16'(vecs[i].e_req));
      if (vecs[i].e_req) chk($sformatf("vec%0d addr", i), imem_bus.imem_addr, vecs[i].e_addr);
      chk($sformatf("vec%0d valid", i), 16'(instr_valid), 16'(vecs[i].e_valid));
      chk($sformatf("vec%0d instr", i), instr_out, vecs[i].e_instr);
      chk($sformatf("vec%0d pp2", i), pc_plus2_out, vecs[i].e_pp2);
      chk($sformatf("vec%0d err", i), 16'(err), 16'h0000);
      tick();
    end

    // PC wrap at 0xFFFE
    drive(0, 1, 16'hFFFE, 0, 0, '0);
    @(negedge clk); chk("wrap redir req", 16'(imem_bus.imem_req), 16'h0000); tick();
    drive(1, 0, '0, 1, 0, '0);
    @(negedge clk); chk("wrap req", 16'(imem_bus.imem_req), 16'h0001);
    chk("wrap addr", imem_bus.imem_addr, 16'hFFFE); tick();
    drive(1, 0, '0, 1, 1, 16'h5555);
    @(negedge clk); chk("wrap wait req", 16'(imem_bus.imem_req), 16'h0000); tick();
    drive(0, 0, '0, 0, 0, '0);
    @(negedge clk); chk("wrap valid", 16'(instr_valid), 16'h0001);
    chk("wrap instr", instr_out, 16'h5555);
    chk("wrap pp2", pc_plus2_out, 16'h0000); tick();
    drive(1, 0, '0, 0, 0, '0);
    @(negedge clk); chk("wrap next addr", imem_bus.imem_addr, 16'h0000);
    chk("wrap next req", 16'(imem_bus.imem_req), 16'h0001); tick();

    // odd redirect target
    drive(1, 1, 16'h0013, 1, 0, '0);
    @(negedge clk); chk("align redir req", 16'(imem_bus.imem_req), 16'h0000); tick();
    drive(0, 0, '0, 0, 0, '0);
    @(negedge clk); chk("align req", 16'(imem_bus.imem_req), 16'h0001);
    chk("align addr", imem_bus.imem_addr, ALIGN ? 16'h0012 : 16'h0013);
    chk("align err", 16'(err), 16'(ALIGN)); tick();
    repeat (3) tick();
    @(negedge clk); chk("align err sticky", 16'(err), 16'(ALIGN)); tick();

    // reset while a request is outstanding
    drive(1, 0, '0, 1, 0, '0);
    tick();
    rst = 1'b0;
    drive(1, 0, '0, 1, 1, 16'h9999);
    repeat (2) tick();
    rst = 1'b1;
    drive(1, 0, '0, 0, 0, '0);
    @(negedge clk);
    chk("rst req", 16'(imem_bus.imem_req), 16'h0001);
    chk("rst addr", imem_bus.imem_addr, 16'h0000);
    chk("rst valid", 16'(instr_valid), 16'h0000);
    chk("rst instr", instr_out, NOP);
    chk("rst pp2", pc_plus2_out, 16'h0000);
    chk("rst err", 16'(err), 16'h0000);

    // randomized traffic against the reference state
    m_pc = 16'h0000; m_busy = 0; m_stale = 0; m_bv = 0; m_bd = NOP;
    m_bpp2 = 16'h0000; m_err = 0; m_oaddr = 16'h0000;
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic wr, rd, rdy, rv, exp_req;
      logic [15:0] rpc, rdata, tgt;
      wr    = ($urandom_range(0, 3) != 0);
      rd    = ($urandom_range(0, 9) == 0);
      rpc   = 16'($urandom);
      if ($urandom_range(0, 3) != 0) rpc[0] = 1'b0;
      rdy   = ($urandom_range(0, 2) != 0);
      rv    = m_busy ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
      rdata = (m_busy && !m_stale) ? mem_fn(m_oaddr) : 16'($urandom);
      drive(wr, rd, rpc, rdy, rv, rdata);

      exp_req = !m_busy && !rd && (!m_bv || wr);
      @(negedge clk);
      chk("rnd req", 16'(imem_bus.imem_req), 16'(exp_req));
      if (exp_req) chk("rnd addr", imem_bus.imem_addr, m_pc);
      chk("rnd valid", 16'(instr_valid), 16'(m_bv));
      chk("rnd instr", instr_out, m_bv ? m_bd : NOP);
      chk("rnd pp2", pc_plus2_out, m_bpp2);
      chk("rnd err", 16'(err), 16'(m_err));

      tgt = ALIGN ? (rpc & 16'hFFFE) : rpc;
      if (rd) begin
        m_err = m_err | (ALIGN & rpc[0]);
        m_pc  = tgt;
        m_bv  = 0;
        if (m_busy) begin
          if (rv) begin m_busy = 0; m_stale = 0; end
          else m_stale = 1;
        end
      end else begin
        if (m_bv && wr) m_bv = 0;
        if (exp_req && rdy) begin
          m_busy  = 1;
          m_stale = 0;
          m_oaddr = m_pc;
          m_pc    = m_pc + 16'd2;
        end else if (m_busy && rv) begin
          if (!m_stale) begin
            m_bv   = 1;
            m_bd   = rdata;
            m_bpp2 = m_oaddr + 16'd2;
          end
          m_busy  = 0;
          m_stale = 0;
        end
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
